// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS32 control unit: state codes, ISA fields,
// control-word layout and ALU operation codes.
package mc_control_fsm_pkg;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM      = 3'd3,
    ST_WB       = 3'd4,
    ST_MDU_WAIT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09, FN_MFHI  = 6'h10, FN_MFLO = 6'h12, FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU = 6'h1B, FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB   = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25, FN_XOR   = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1;

  localparam logic [1:0] CTRL_DST_RT = 2'd0, CTRL_DST_RD = 2'd1, CTRL_DST_RA = 2'd2;
  localparam logic [1:0] CTRL_JMP_NONE = 2'd0, CTRL_JMP_IMM = 2'd1, CTRL_JMP_REG = 2'd2;
  localparam logic [2:0] CTRL_BR_NONE = 3'd0, CTRL_BR_BEQ = 3'd1, CTRL_BR_BNE = 3'd2, CTRL_BR_BLEZ = 3'd3;
  localparam logic [2:0] CTRL_BR_BGTZ = 3'd4, CTRL_BR_BLTZ = 3'd5, CTRL_BR_BGEZ = 3'd6;
  localparam logic [1:0] CTRL_DT_WORD = 2'd0, CTRL_DT_HALF = 2'd1, CTRL_DT_BYTE = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MULT = 4'd12, ALU_DIV  = 4'd13, ALU_MFHI = 4'd14, ALU_MFLO = 4'd15;

  // Bit offsets of each field in the packed control word (MSB first).
  localparam int CW_HI_WRITE  = 20;
  localparam int CW_LO_WRITE  = 19;
  localparam int CW_REG_DST   = 17;
  localparam int CW_ALU_SRC   = 16;
  localparam int CW_ALU_OP    = 12;
  localparam int CW_MEM_WRITE = 11;
  localparam int CW_MEM_READ  = 10;
  localparam int CW_MEMTOREG  = 9;
  localparam int CW_REG_WRITE = 8;
  localparam int CW_BRANCH    = 5;
  localparam int CW_JUMP      = 3;
  localparam int CW_SIGN_EXT  = 2;
  localparam int CW_DATA_TYPE = 0;

  // For loads sign_ext selects loaded-data extension; address offsets are always signed.
  typedef struct packed {
    logic       hi_write;
    logic       lo_write;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
    logic [2:0] branch;
    logic [1:0] jump;
    logic       sign_ext;
    logic [1:0] data_type;
  } ctrl_t;

  function automatic logic is_mdu(input ctrl_t c);
    return c.hi_write & c.lo_write;
  endfunction

  function automatic logic [1:0] data_type_of(input logic [1:0] size_bits);
    case (size_bits)
      2'b00:   return CTRL_DT_BYTE;
      2'b01:   return CTRL_DT_HALF;
      default: return CTRL_DT_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control-unit bundle: IR fields and memory handshake in, datapath strobes, latched
// control word and trace outputs out. master = control unit, slave = datapath/memory.
interface mc_control_fsm_if #(
  parameter int CW_W      = 21,
  parameter int RET_CNT_W = 32
);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic [4:0]           rt;
  logic                 mem_ack;
  logic                 mem_req;
  logic                 mem_we;
  logic                 ir_write;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 reg_write;
  logic                 mdu_start;
  logic [CW_W-1:0]      control_word;
  logic [2:0]           state;
  logic                 illegal;
  logic [RET_CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, rt, mem_ack,
    output mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write,
           mdu_start, control_word, state, illegal, retired
  );

  modport slave (
    output opcode, funct, rt, mem_ack,
    input  mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write,
           mdu_start, control_word, state, illegal, retired
  );
endinterface

// File: rtl/mc_control_fsm_decode.sv
// Combinational MIPS32 decoder: opcode/funct/rt to control word plus illegal flag.
// Zero latency; no handshake. Undefined encodings yield an all-zero word.
module mc_decode
  import mc_control_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output ctrl_t      cw,
  output logic       illegal
);

  ctrl_t c;
  logic  bad;

  always_comb begin
    c   = '0;
    bad = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_dst   = CTRL_DST_RD;
        c.reg_write = 1'b1;
        case (funct)
          FN_SLL:          c.alu_op = ALU_SLL;
          FN_SRL:          c.alu_op = ALU_SRL;
          FN_SRA:          c.alu_op = ALU_SRA;
          FN_JR: begin
            c.reg_write = 1'b0;
            c.jump      = CTRL_JMP_REG;
          end
          FN_JALR:         c.jump   = CTRL_JMP_REG;
          FN_MFHI:         c.alu_op = ALU_MFHI;
          FN_MFLO:         c.alu_op = ALU_MFLO;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            c.reg_write = 1'b0;
            c.hi_write  = 1'b1;
            c.lo_write  = 1'b1;
            c.alu_op    = funct[1] ? ALU_DIV : ALU_MULT;
            c.sign_ext  = ~funct[0];   // odd funct = unsigned variant
          end
          FN_ADD, FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:          c.alu_op = ALU_AND;
          FN_OR:           c.alu_op = ALU_OR;
          FN_XOR:          c.alu_op = ALU_XOR;
          FN_NOR:          c.alu_op = ALU_NOR;
          FN_SLT:          c.alu_op = ALU_SLT;
          FN_SLTU:         c.alu_op = ALU_SLTU;
          default:         bad      = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        c.alu_op   = ALU_SUB;
        c.sign_ext = 1'b1;
        case (rt)
          RT_BLTZ: c.branch = CTRL_BR_BLTZ;
          RT_BGEZ: c.branch = CTRL_BR_BGEZ;
          default: bad      = 1'b1;
        endcase
      end
      OP_J:   c.jump = CTRL_JMP_IMM;
      OP_JAL: begin
        c.jump      = CTRL_JMP_IMM;
        c.reg_dst   = CTRL_DST_RA;
        c.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        c.alu_op   = ALU_SUB;
        c.sign_ext = 1'b1;
        c.branch   = {1'b0, opcode[1:0]} + CTRL_BR_BEQ;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.sign_ext  = ~opcode[2];
        case (opcode[2:0])
          3'd0, 3'd1: c.alu_op = ALU_ADD;
          3'd2:       c.alu_op = ALU_SLT;
          3'd3:       c.alu_op = ALU_SLTU;
          3'd4:       c.alu_op = ALU_AND;
          3'd5:       c.alu_op = ALU_OR;
          3'd6:       c.alu_op = ALU_XOR;
          default:    c.alu_op = ALU_LUI;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.sign_ext   = ~opcode[2];
        c.data_type  = data_type_of(opcode[1:0]);
      end
      OP_SB, OP_SH, OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.sign_ext  = 1'b1;
        c.data_type = data_type_of(opcode[1:0]);
      end
      default: bad = 1'b1;
    endcase
    if (bad) c = '0;
  end

  assign cw      = c;
  assign illegal = bad;

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 control FSM: decodes once, latches the control word, steps FETCH..WB.
// 2-5 cycles per instruction (3+LAT for MDU); stalls in FETCH/MEM until mem_ack.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int CW_W      = 21,
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 32,
  parameter int RET_CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_control_fsm_if.master bus
);

  localparam int MAX_LAT   = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MDU_CNT_W = $clog2(MAX_LAT + 1);

  state_t                 state_q, state_d;
  logic [CW_W-1:0]        cw_q;
  ctrl_t                  cur_cw, dec_cw;
  logic                   dec_illegal;
  logic [MDU_CNT_W-1:0]   mdu_cnt_q, mdu_cnt_d;
  logic [RET_CNT_W-1:0]   retired_q;
  logic                   retire;
  logic mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write, mdu_start, illegal;

  mc_decode u_decode (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .rt      (bus.rt),
    .cw      (dec_cw),
    .illegal (dec_illegal)
  );

  assign cur_cw = ctrl_t'(cw_q);

  always_comb begin
    state_d       = state_q;
    mdu_cnt_d     = mdu_cnt_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    mdu_start     = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      // The word is only latched on exit, so this state steers from the live decode.
      ST_DECODE: begin
        if (dec_illegal) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else if (dec_cw.jump != CTRL_JMP_NONE) begin
          pc_write = 1'b1;
          state_d  = dec_cw.reg_write ? ST_WB : ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cur_cw.branch != CTRL_BR_NONE) begin
          pc_write_cond = 1'b1;
          state_d       = ST_FETCH;
        end else if (is_mdu(cur_cw)) begin
          mdu_start = 1'b1;
          mdu_cnt_d = (cur_cw.alu_op == ALU_DIV) ? MDU_CNT_W'(DIV_LAT) : MDU_CNT_W'(MUL_LAT);
          state_d   = ST_MDU_WAIT;
        end else if (cur_cw.mem_read || cur_cw.mem_write) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MDU_WAIT: begin
        mdu_cnt_d = mdu_cnt_q - MDU_CNT_W'(1);
        if (mdu_cnt_q <= MDU_CNT_W'(1)) state_d = ST_FETCH;
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = cur_cw.mem_write;
        if (bus.mem_ack) state_d = cur_cw.mem_read ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    retire = (state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q <= ST_MDU_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cw_q      <= '0;
      mdu_cnt_q <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      if (state_q == ST_DECODE) cw_q <= dec_cw;
      if (retire) retired_q <= retired_q + RET_CNT_W'(1);
    end
  end

  // Strobes are forced low for the whole time reset is held.
  assign bus.mem_req       = mem_req & rst_n;
  assign bus.mem_we        = mem_we & rst_n;
  assign bus.ir_write      = ir_write & rst_n;
  assign bus.pc_write      = pc_write & rst_n;
  assign bus.pc_write_cond = pc_write_cond & rst_n;
  assign bus.reg_write     = reg_write & rst_n;
  assign bus.mdu_start     = mdu_start & rst_n;
  assign bus.illegal       = illegal & rst_n;
  assign bus.control_word  = cw_q;
  assign bus.state         = state_q;
  assign bus.retired       = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Cycle-by-cycle vector bench for mc_control_fsm: a table of per-cycle inputs and
// expected state/strobes/retired, plus hand-built reset and counter-wrap sequences.
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_X = 3'd5;
  // strobes = {mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write, mdu_start, illegal}
  localparam logic [7:0] NONE = 8'b0000_0000, FA = 8'b1011_0000, MRD = 8'b1000_0000;
  localparam logic [7:0] MWR  = 8'b1100_0000, PCW = 8'b0001_0000, PCC = 8'b0000_1000;
  localparam logic [7:0] RW   = 8'b0000_0100, MDU = 8'b0000_0010, ILL = 8'b0000_0001;
  localparam logic [20:0] B_HI  = 21'h1 << CW_HI_WRITE,  B_LO  = 21'h1 << CW_LO_WRITE;
  localparam logic [20:0] B_MW  = 21'h1 << CW_MEM_WRITE, B_MR  = 21'h1 << CW_MEM_READ;
  localparam logic [20:0] B_M2R = 21'h1 << CW_MEMTOREG,  B_RW  = 21'h1 << CW_REG_WRITE;
  localparam logic [20:0] ALL   = 21'h1F_FFFF;

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic        ack;
    logic [2:0]  st;
    logic [7:0]  stb;
    logic [3:0]  ret;
    logic [20:0] cw_mask;
    logic [20:0] cw_val;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   step_no = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  mc_control_fsm_if #(.CW_W(21), .RET_CNT_W(4)) bus ();

  mc_control_fsm #(.CW_W(21), .MUL_LAT(4), .DIV_LAT(6), .RET_CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                              input logic ack, input logic [2:0] st, input logic [7:0] stb,
                              input logic [3:0] ret, input logic [20:0] m, input logic [20:0] v);
    vec_t r;
    r.opcode = op; r.funct = fn; r.rt = rt; r.ack = ack;
    r.st = st; r.stb = stb; r.ret = ret; r.cw_mask = m; r.cw_val = v;
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, step_no, act, exp);
  endtask

  // Drive one cycle of inputs, queue its expectation, then compare mid-cycle.
  task automatic step(input vec_t v);
    vec_t e;
    bus.opcode  = v.opcode;
    bus.funct   = v.funct;
    bus.rt      = v.rt;
    bus.mem_ack = v.ack;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check("state", {29'd0, bus.state}, {29'd0, e.st});
    check("strobes", {24'd0, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write,
                      bus.pc_write_cond, bus.reg_write, bus.mdu_start, bus.illegal},
          {24'd0, e.stb});
    check("retired", {28'd0, bus.retired}, {28'd0, e.ret});
    if (e.cw_mask != 21'd0)
      check("control_word", {11'd0, bus.control_word & e.cw_mask}, {11'd0, e.cw_val});
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                         input logic ack, input logic [2:0] st, input logic [7:0] stb,
                         input logic [3:0] ret, input logic [20:0] m, input logic [20:0] v);
    vec_t r;
    r.opcode = op; r.funct = fn; r.rt = rt; r.ack = ack;
    r.st = st; r.stb = stb; r.ret = ret; r.cw_mask = m; r.cw_val = v;
    step(r);
  endtask

  initial begin
    // ADDU, all-ack memory
    add(6'h00, 6'h21, 5'd0, 1'b1, S_F, FA,   4'd0, 21'd0, 21'd0);
    add(6'h00, 6'h21, 5'd0, 1'b1, S_D, NONE, 4'd0, 21'd0, 21'd0);
    add(6'h00, 6'h21, 5'd0, 1'b1, S_E, NONE, 4'd0, 21'd0, 21'd0);
    add(6'h00, 6'h21, 5'd0, 1'b1, S_W, RW,   4'd0, B_RW | B_M2R, B_RW);
    // LW, acks outside FETCH/MEM ignored, three-cycle MEM
    add(6'h23, 6'h00, 5'd0, 1'b1, S_F, FA,   4'd1, 21'd0, 21'd0);
    add(6'h23, 6'h00, 5'd0, 1'b1, S_D, NONE, 4'd1, 21'd0, 21'd0);
    add(6'h23, 6'h00, 5'd0, 1'b1, S_E, NONE, 4'd1, 21'd0, 21'd0);
    add(6'h23, 6'h00, 5'd0, 1'b0, S_M, MRD,  4'd1, B_MW | B_MR, B_MR);
    add(6'h23, 6'h00, 5'd0, 1'b0, S_M, MRD,  4'd1, 21'd0, 21'd0);
    add(6'h23, 6'h00, 5'd0, 1'b1, S_M, MRD,  4'd1, 21'd0, 21'd0);
    add(6'h23, 6'h00, 5'd0, 1'b0, S_W, RW,   4'd1, B_M2R | B_MW, B_M2R);
    // MULT: four MDU_WAIT cycles
    add(6'h00, 6'h18, 5'd0, 1'b1, S_F, FA,   4'd2, 21'd0, 21'd0);
    add(6'h00, 6'h18, 5'd0, 1'b0, S_D, NONE, 4'd2, 21'd0, 21'd0);
    add(6'h00, 6'h18, 5'd0, 1'b0, S_E, MDU,  4'd2, 21'd0, 21'd0);
    for (int i = 0; i < 3; i++) add(6'h00, 6'h18, 5'd0, 1'b1, S_X, NONE, 4'd2, 21'd0, 21'd0);
    add(6'h00, 6'h18, 5'd0, 1'b0, S_X, NONE, 4'd2, B_HI | B_LO | B_RW, B_HI | B_LO);
    // BGEZ then undefined opcode 0x3F
    add(6'h01, 6'h00, 5'd1, 1'b1, S_F, FA,   4'd3, 21'd0, 21'd0);
    add(6'h01, 6'h00, 5'd1, 1'b0, S_D, NONE, 4'd3, 21'd0, 21'd0);
    add(6'h01, 6'h00, 5'd1, 1'b0, S_E, PCC,  4'd3, 21'd0, 21'd0);
    add(6'h3F, 6'h00, 5'd0, 1'b1, S_F, FA,   4'd4, 21'd0, 21'd0);
    add(6'h3F, 6'h00, 5'd0, 1'b0, S_D, ILL,  4'd4, 21'd0, 21'd0);
    // J (illegal left an all-zero control word), JAL
    add(6'h02, 6'h00, 5'd0, 1'b1, S_F, FA,   4'd5, ALL, 21'd0);
    add(6'h02, 6'h00, 5'd0, 1'b0, S_D, PCW,  4'd5, 21'd0, 21'd0);
    add(6'h03, 6'h00, 5'd0, 1'b1, S_F, FA,   4'd6, 21'd0, 21'd0);
    add(6'h03, 6'h00, 5'd0, 1'b0, S_D, PCW,  4'd6, 21'd0, 21'd0);
    add(6'h03, 6'h00, 5'd0, 1'b0, S_W, RW,   4'd6, B_RW, B_RW);
    // DIV: six MDU_WAIT cycles
    add(6'h00, 6'h1A, 5'd0, 1'b1, S_F, FA,   4'd7, 21'd0, 21'd0);
    add(6'h00, 6'h1A, 5'd0, 1'b0, S_D, NONE, 4'd7, 21'd0, 21'd0);
    add(6'h00, 6'h1A, 5'd0, 1'b0, S_E, MDU,  4'd7, 21'd0, 21'd0);
    for (int i = 0; i < 6; i++) add(6'h00, 6'h1A, 5'd0, 1'b0, S_X, NONE, 4'd7, 21'd0, 21'd0);
    // SW zero-wait, then FETCH held without ack
    add(6'h2B, 6'h00, 5'd0, 1'b1, S_F, FA,   4'd8, 21'd0, 21'd0);
    add(6'h2B, 6'h00, 5'd0, 1'b1, S_D, NONE, 4'd8, 21'd0, 21'd0);
    add(6'h2B, 6'h00, 5'd0, 1'b1, S_E, NONE, 4'd8, 21'd0, 21'd0);
    add(6'h2B, 6'h00, 5'd0, 1'b1, S_M, MWR,  4'd8, B_MW | B_MR | B_RW, B_MW);
    add(6'h02, 6'h00, 5'd0, 1'b0, S_F, MRD,  4'd9, 21'd0, 21'd0);
    add(6'h02, 6'h00, 5'd0, 1'b0, S_F, MRD,  4'd9, 21'd0, 21'd0);

    // Reset held with ack high: everything quiet.
    rst_n = 1'b0;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.rt = 5'd0; bus.mem_ack = 1'b1;
    @(posedge clk);
    #1;
    run_row(6'h00, 6'h00, 5'd0, 1'b1, S_F, NONE, 4'd0, ALL, 21'd0);
    rst_n = 1'b1;

    // SW stalled in MEM, then aborted by reset.
    run_row(6'h2B, 6'h00, 5'd0, 1'b1, S_F, FA,   4'd0, 21'd0, 21'd0);
    run_row(6'h2B, 6'h00, 5'd0, 1'b0, S_D, NONE, 4'd0, 21'd0, 21'd0);
    run_row(6'h2B, 6'h00, 5'd0, 1'b0, S_E, NONE, 4'd0, 21'd0, 21'd0);
    run_row(6'h2B, 6'h00, 5'd0, 1'b0, S_M, MWR,  4'd0, B_MW, B_MW);
    run_row(6'h2B, 6'h00, 5'd0, 1'b0, S_M, MWR,  4'd0, 21'd0, 21'd0);
    rst_n = 1'b0;
    run_row(6'h2B, 6'h00, 5'd0, 1'b1, S_F, NONE, 4'd0, ALL, 21'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset clears a non-zero count, then 17 J instructions wrap the 4-bit counter.
    rst_n = 1'b0;
    run_row(6'h02, 6'h00, 5'd0, 1'b0, S_F, NONE, 4'd0, ALL, 21'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      run_row(6'h02, 6'h00, 5'd0, 1'b1, S_F, FA,  4'(i % 16), 21'd0, 21'd0);
      run_row(6'h02, 6'h00, 5'd0, 1'b0, S_D, PCW, 4'(i % 16), 21'd0, 21'd0);
    end
    run_row(6'h02, 6'h00, 5'd0, 1'b0, S_F, MRD, 4'd1, 21'd0, 21'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle MIPS32 control unit, the sequential successor of the single-cycle combinational decoder. It decodes opcode/funct/rt once per instruction and latches the resulting control word. It then steps a FETCH/DECODE/EXEC/MEM/WB/MDU_WAIT state machine that issues per-state datapath strobes, handshakes with instruction/data memory, and waits a parametrised latency for multiply/divide. It sits between the IR and the multi-cycle datapath and replaces the combinational control unit in the multi-cycle core.

Parameters:
CW_W, 21, control-word width; field order HI_WRITE..DATA_TYPE per the shared control encoding.
MUL_LAT, 4, MDU_WAIT cycles for MULT/MULTU (>=1).
DIV_LAT, 32, MDU_WAIT cycles for DIV/DIVU (>=1).
RET_CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26]; valid from DECODE onward
funct  in  6  IR[5:0]
rt  in  5  IR[20:16]; selects REGIMM branches (BLTZ=0, BGEZ=1)
mem_ack  in  1  memory completes the current request this cycle
mem_req  out  1  memory request; high in FETCH and MEM until acked
mem_we  out  1  write qualifier; high only in MEM for stores
ir_write  out  1  IR load strobe; FETCH & mem_ack
pc_write  out  1  unconditional PC update (PC+4 in FETCH; target in DECODE for jumps)
pc_write_cond  out  1  branch PC update, EXEC of a branch, gated by datapath zero/compare
reg_write  out  1  register-file write; WB only
mdu_start  out  1  one-cycle pulse in EXEC for MULT/MULTU/DIV/DIVU
control_word  out  CW_W  latched decode; held stable from DECODE exit to instruction end
state  out  3  current state, for debug/trace
illegal  out  1  one-cycle pulse in DECODE on an undefined opcode/funct
retired  out  RET_CNT_W  count of completed instructions; wraps modulo 2^RET_CNT_W

Behaviour:
- Reset, asynchronous on rst_n low: state=FETCH, control_word=0, retired=0. All strobes are 0 while rst_n is low. The first mem_req appears in the first cycle after deassertion.
- States use 3-bit encoding from the package: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDU_WAIT=5. Codes 6 and 7 return to FETCH on the next edge.
- FETCH: mem_req=1, mem_we=0. It holds until mem_ack. In the ack cycle ir_write=1 and pc_write=1 (PC+4), and the next state is DECODE.
- DECODE: the decoder evaluates, and control_word is registered at the exit edge.
  - J: pc_write=1, instruction complete, next state FETCH.
  - JAL/JALR: pc_write=1, next state WB (link write).
  - JR: pc_write=1, next state FETCH.
  - Undefined encoding: illegal=1, instruction completes as a NOP, next state FETCH.
  - All others: next state EXEC.
- EXEC:
  - Branches (BEQ/BNE/BLEZ/BGTZ/REGIMM): pc_write_cond=1, then FETCH.
  - MULT/MULTU/DIV/DIVU: mdu_start=1; the counter loads MUL_LAT or DIV_LAT; next state MDU_WAIT.
  - Loads and stores go to MEM. Everything else goes to WB.
- MDU_WAIT: the counter decrements each cycle; at 1 the next state is FETCH. Total dwell is exactly the LAT cycles.
- MEM: mem_req=1, and mem_we=MEMWRITE. It holds until mem_ack. On ack a load goes to WB and a store goes to FETCH.
- WB: reg_write=1 for one cycle, then FETCH.
- Completion: retired increments on the edge that ends the instruction's final state. That is the transition into FETCH from DECODE, EXEC, MDU_WAIT, MEM or WB, including illegal NOPs.
- mem_ack outside FETCH/MEM is ignored. mem_req stays high across wait cycles.
- Reset mid-operation (for example in MEM awaiting ack or in MDU_WAIT) aborts immediately. retired does not count the aborted instruction.
- Latency with zero-wait memory:
  - 2 cycles: J, JR
  - 3 cycles: branches, JAL
  - 4 cycles: R/I ALU ops, stores
  - 5 cycles: loads
  - 2+LAT cycles: MDU ops, plus 1 for FETCH

Decomposition:
- Shared include package holds:
  - state codes;
  - OP_*/FN_*/RT_* ISA constants;
  - CTRL_*/ALU_* encodings;
  - control-word field offsets.
- One combinational sub-module, mc_decode: opcode, funct, rt -> CW_W control word plus the illegal flag. It uses rt rather than funct for REGIMM and gives every path a default assignment (no latches).
- The FSM, MDU counter and retire counter live in the top module.

Test Plan:
- Reset, then ADDU (opcode 0x00, funct 0x21) with mem_ack tied high -> states 0,1,2,4,0. reg_write is high only in cycle 4 and retired=1.
- LW (opcode 0x23) with mem_ack delayed 3 cycles in MEM -> mem_req high 3 cycles in MEM, MEMTOREG=1 in control_word, reg_write in WB, 7 cycles total.
- MULT (funct 0x18), MUL_LAT=4 -> single mdu_start pulse, exactly 4 cycles in state 5, reg_write never asserted, HI_WRITE/LO_WRITE set in control_word.
- BGEZ (opcode 0x01, rt=1) then opcode 0x3F -> branch takes 3 cycles with pc_write_cond; 0x3F pulses illegal in DECODE, returns to FETCH, retired=2.
- rst_n low during MEM of SW (0x2B) awaiting ack -> state=0, outputs 0, retired unchanged. FETCH resumes on the next cycle after release.
- RET_CNT_W=4, retire 17 J instructions -> retired wraps to 1.
